// File: rtl/seq_det_pkg.sv
// Shared definitions for the multi-pattern serial sequence detector.
//   LEN_W / SEL_W : width helpers for the pattern-length and pattern-select fields.
//   DEF_PAT0/1    : reset patterns that reproduce the legacy fixed 2-pattern detector.
//   DEF_LEN       : reset length of those two patterns.
package seq_det_pkg;

    function automatic int unsigned LEN_W(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int unsigned SEL_W(input int unsigned num_pat);
        return (num_pat > 1) ? $clog2(num_pat) : 1;
    endfunction

    localparam int unsigned DEF_LEN  = 4;
    localparam logic [3:0]  DEF_PAT0 = 4'b1110;
    localparam logic [3:0]  DEF_PAT1 = 4'b0001;

endpackage

// File: rtl/seq_det_chan.sv
// One pattern channel of the sequence detector.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : the shared history advances this cycle
//   hist_next  : shared history as it will be after this edge (newest bit at [0])
//   cfg_we     : configuration write addressed to this channel
//   cfg_pat/len/ovl/en : configuration values
//   cnt_clr    : clear the match counter
//   match_o    : registered one-cycle match pulse
//   cnt_o      : saturating match counter
module seq_det_chan
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8,
    parameter logic [31:0] RST_PAT = '0,
    parameter int unsigned RST_LEN = 0,
    parameter bit          RST_OVL = 1'b0,
    parameter bit          RST_EN  = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [MAX_LEN-1:0]        hist_next,
    input  logic                      cfg_we,
    input  logic [MAX_LEN-1:0]        cfg_pat,
    input  logic [LEN_W(MAX_LEN)-1:0] cfg_len,
    input  logic                      cfg_ovl,
    input  logic                      cfg_en,
    input  logic                      cnt_clr,
    output logic                      match_o,
    output logic [CNT_W-1:0]          cnt_o
);

    localparam int unsigned   LW        = LEN_W(MAX_LEN);
    localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);
    localparam logic [LW-1:0] RST_LEN_L = LW'(RST_LEN);
    localparam logic          RST_EN_L  = RST_EN && (RST_LEN >= 1) && (RST_LEN <= MAX_LEN);

    logic [MAX_LEN-1:0] pat_q;
    logic [LW-1:0]      len_q;
    logic               ovl_q;
    logic               en_q;
    // Valid bits seen since the last clear, saturating at MAX_LEN. Stops the
    // zero-filled history after reset/config from producing false matches.
    logic [LW-1:0]      fill_q;
    logic               match_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [MAX_LEN-1:0] len_mask;
    logic               fill_ok;
    logic               pat_ok;
    logic               hit;

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LW'(i) < len_q);
        end
    end

    assign fill_ok = ({1'b0, fill_q} + (LW + 1)'(1)) >= {1'b0, len_q};
    assign pat_ok  = ((hist_next ^ pat_q) & len_mask) == '0;
    assign hit     = in_valid && en_q && (len_q != '0) && fill_ok && pat_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= RST_PAT[MAX_LEN-1:0];
            len_q   <= RST_LEN_L;
            ovl_q   <= RST_OVL;
            en_q    <= RST_EN_L;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            match_q <= hit && !cfg_we;
            if (cfg_we) begin
                pat_q  <= cfg_pat;
                len_q  <= cfg_len;
                ovl_q  <= cfg_ovl;
                en_q   <= cfg_en && (cfg_len != '0) && (cfg_len <= LEN_MAX);
                fill_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (in_valid) begin
                    // Non-overlap: restart so the next match needs len fresh bits.
                    if (hit && !ovl_q) begin
                        fill_q <= '0;
                    end else if (fill_q < LEN_MAX) begin
                        fill_q <= fill_q + LW'(1);
                    end
                end
                if (cnt_clr) begin
                    cnt_q <= '0;
                end else if (match_q && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign match_o = match_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/seq_detector_multi.sv
// Runtime-programmable multi-pattern serial sequence detector.
//   clk, rst     : clock, synchronous active-high reset
//   in_bit       : serial data, sampled when in_valid = 1
//   cfg_we/sel   : write pattern cfg_sel (out-of-range selects are ignored)
//   cfg_pat/len/ovl/en : pattern bits (bit [len-1] received first), length, overlap, enable
//   cnt_clr      : clear all match counters
//   match_o      : per-pattern one-cycle match pulse
//   any_match_o  : OR of match_o
//   match_cnt_o  : saturating counters, pattern k at [k*CNT_W +: CNT_W]
module seq_detector_multi
    import seq_det_pkg::*;
#(
    parameter int unsigned NUM_PAT = 2,
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_bit,
    input  logic                      in_valid,
    input  logic                      cfg_we,
    input  logic [SEL_W(NUM_PAT)-1:0] cfg_sel,
    input  logic [MAX_LEN-1:0]        cfg_pat,
    input  logic [LEN_W(MAX_LEN)-1:0] cfg_len,
    input  logic                      cfg_ovl,
    input  logic                      cfg_en,
    input  logic                      cnt_clr,
    output logic [NUM_PAT-1:0]        match_o,
    output logic                      any_match_o,
    output logic [NUM_PAT*CNT_W-1:0]  match_cnt_o
);

    localparam int unsigned SW = SEL_W(NUM_PAT);

    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] hist_next;

    assign hist_next = in_valid ? {hist_q[MAX_LEN-2:0], in_bit} : hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_next;
        end
    end

    for (genvar k = 0; k < NUM_PAT; k++) begin : g_chan
        // Channels 0 and 1 come up as the legacy fixed patterns.
        localparam logic [31:0] RST_PAT = (k == 0) ? 32'(DEF_PAT0) :
                                          (k == 1) ? 32'(DEF_PAT1) : 32'd0;
        localparam int unsigned RST_LEN = (k < 2) ? DEF_LEN : 0;

        logic cfg_hit;
        assign cfg_hit = cfg_we && (cfg_sel == SW'(k));

        seq_det_chan #(
            .MAX_LEN (MAX_LEN),
            .CNT_W   (CNT_W),
            .RST_PAT (RST_PAT),
            .RST_LEN (RST_LEN),
            .RST_OVL (k < 2),
            .RST_EN  (k < 2)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .hist_next (hist_next),
            .cfg_we    (cfg_hit),
            .cfg_pat   (cfg_pat),
            .cfg_len   (cfg_len),
            .cfg_ovl   (cfg_ovl),
            .cfg_en    (cfg_en),
            .cnt_clr   (cnt_clr),
            .match_o   (match_o[k]),
            .cnt_o     (match_cnt_o[k*CNT_W +: CNT_W])
        );
    end

    assign any_match_o = |match_o;

endmodule

// File: tb/tb_seq_detector_multi.sv
// Bench for seq_detector_multi: vector table, directed sequences and a random run
// checked against a stream-level reference model.
module tb_seq_detector_multi;

    localparam int NP = 3;
    localparam int ML = 8;
    localparam int CW = 2;
    localparam int SW = 2;
    localparam int LW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_bit = 1'b0;
    logic              in_valid = 1'b0;
    logic              cfg_we = 1'b0;
    logic [SW-1:0]     cfg_sel = '0;
    logic [ML-1:0]     cfg_pat = '0;
    logic [LW-1:0]     cfg_len = '0;
    logic              cfg_ovl = 1'b0;
    logic              cfg_en = 1'b0;
    logic              cnt_clr = 1'b0;
    logic [NP-1:0]     match_o;
    logic              any_match_o;
    logic [NP*CW-1:0]  match_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_detector_multi #(
        .NUM_PAT (NP),
        .MAX_LEN (ML),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_bit      (in_bit),
        .in_valid    (in_valid),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_pat     (cfg_pat),
        .cfg_len     (cfg_len),
        .cfg_ovl     (cfg_ovl),
        .cfg_en      (cfg_en),
        .cnt_clr     (cnt_clr),
        .match_o     (match_o),
        .any_match_o (any_match_o),
        .match_cnt_o (match_cnt_o)
    );

    // Reference model: every valid bit since reset, plus per pattern the stream
    // index where its usable ("fresh") bits begin.
    bit            stream_q[$];
    int            start_idx[NP];
    logic [ML-1:0] m_pat[NP];
    int            m_len[NP];
    bit            m_ovl[NP];
    bit            m_en[NP];
    bit            exp_m[NP];
    int            exp_cnt[NP];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit tail_match(input int k);
        int n = stream_q.size();
        for (int i = 0; i < m_len[k]; i++) begin
            if (stream_q[n - 1 - i] != m_pat[k][i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge(input bit r, input bit v, input bit b, input bit we, input int sel,
                              input logic [ML-1:0] pat, input int len, input bit ovl,
                              input bit en, input bit clr);
        if (r) begin
            stream_q.delete();
            for (int k = 0; k < NP; k++) begin
                start_idx[k] = 0;
                exp_m[k]     = 1'b0;
                exp_cnt[k]   = 0;
                m_pat[k]     = (k == 0) ? 8'b1110 : (k == 1) ? 8'b0001 : 8'b0;
                m_len[k]     = (k < 2) ? 4 : 0;
                m_ovl[k]     = (k < 2);
                m_en[k]      = (k < 2);
            end
        end else begin
            for (int k = 0; k < NP; k++) begin
                if ((we && sel == k) || clr) exp_cnt[k] = 0;
                else if (exp_m[k] && exp_cnt[k] < (1 << CW) - 1) exp_cnt[k]++;
            end
            if (v) stream_q.push_back(b);
            for (int k = 0; k < NP; k++) begin
                bit hit;
                hit = v && m_en[k] && (m_len[k] >= 1) &&
                      (stream_q.size() - start_idx[k] >= m_len[k]) && tail_match(k);
                if (we && sel == k) begin
                    m_pat[k]     = pat;
                    m_len[k]     = len;
                    m_ovl[k]     = ovl;
                    m_en[k]      = en && (len >= 1) && (len <= ML);
                    start_idx[k] = stream_q.size();
                    hit          = 1'b0;
                end else if (hit && !m_ovl[k]) begin
                    start_idx[k] = stream_q.size();
                end
                exp_m[k] = hit;
            end
        end
    endtask

    task automatic tick(input bit r, input bit v, input bit b, input bit we, input int sel,
                        input logic [ML-1:0] pat, input int len, input bit ovl, input bit en,
                        input bit clr);
        logic [NP-1:0]    em;
        logic [NP*CW-1:0] ec;
        rst      = r;
        in_valid = v;
        in_bit   = b;
        cfg_we   = we;
        cfg_sel  = SW'(sel);
        cfg_pat  = pat;
        cfg_len  = LW'(len);
        cfg_ovl  = ovl;
        cfg_en   = en;
        cnt_clr  = clr;
        model_edge(r, v, b, we, sel, pat, len, ovl, en, clr);
        @(posedge clk);
        #1;
        for (int k = 0; k < NP; k++) begin
            em[k]           = exp_m[k];
            ec[k*CW +: CW]  = CW'(exp_cnt[k]);
        end
        check("model_match", match_o, em);
        check("model_any", any_match_o, |em);
        check("model_cnt", match_cnt_o, ec);
    endtask

    task automatic send(input bit b);
        tick(1'b0, 1'b1, b, 1'b0, 0, '0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 0, '0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_rst();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 0, '0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cfg(input int sel, input logic [ML-1:0] pat, input int len, input bit ovl,
                       input bit en);
        tick(1'b0, 1'b0, 1'b0, 1'b1, sel, pat, len, ovl, en, 1'b0);
    endtask

    typedef struct {
        bit         r;
        bit         v;
        bit         b;
        bit         clr;
        logic [2:0] m;
        int         c0;
        int         c1;
    } vec_t;

    vec_t tbl[31];
    int   pulses;

    initial begin
        // Defaults, zero-filled history, reset mid-stream, valid gaps, cnt_clr vs match.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 0, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 0, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 0, 0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 0, 0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 0, 0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1, 0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1, 0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1, 0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1, 0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 1, 0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1, 1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 0, 0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 0, 0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 0, 0};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 0, 0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 0, 0};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 0, 0};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 0, 0};
        tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 0, 0};
        tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 0, 0};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 0, 0};
        tbl[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 0, 0};
        tbl[22] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 0, 0};
        tbl[23] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 0, 0};
        tbl[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1, 0};
        tbl[25] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1, 0};
        tbl[26] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1, 0};
        tbl[27] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1, 0};
        tbl[28] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 1, 0};
        tbl[29] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 0, 0};
        tbl[30] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 0, 0};

        for (int i = 0; i < 31; i++) begin
            tick(tbl[i].r, tbl[i].v, tbl[i].b, 1'b0, 0, '0, 0, 1'b0, 1'b0, tbl[i].clr);
            check($sformatf("tbl%0d_match", i), match_o, tbl[i].m);
            check($sformatf("tbl%0d_cnt0", i), match_cnt_o[1:0], tbl[i].c0);
            check($sformatf("tbl%0d_cnt1", i), match_cnt_o[3:2], tbl[i].c1);
        end

        // Overlapping 11 on 1111: three pulses.
        do_rst();
        cfg(0, 8'b11, 2, 1'b1, 1'b1);
        pulses = 0;
        repeat (4) begin send(1'b1); pulses += int'(match_o[0]); end
        idle();
        check("ovl_pulses", pulses, 3);
        check("ovl_cnt0", match_cnt_o[1:0], 3);

        // Non-overlapping: two pulses, counter restarted by the write.
        cfg(0, 8'b11, 2, 1'b0, 1'b1);
        check("ovl0_cnt_cleared", match_cnt_o[1:0], 0);
        pulses = 0;
        repeat (4) begin send(1'b1); pulses += int'(match_o[0]); end
        idle();
        check("novl_pulses", pulses, 2);
        check("novl_cnt0", match_cnt_o[1:0], 2);

        // Saturation: five matches on a 2-bit counter.
        cfg(0, 8'b1, 1, 1'b1, 1'b1);
        pulses = 0;
        repeat (5) begin send(1'b1); pulses += int'(match_o[0]); end
        idle();
        check("sat_pulses", pulses, 5);
        check("sat_cnt0", match_cnt_o[1:0], 3);

        // len 0 and len > MAX_LEN disable the pattern; len 1 then fires.
        cfg(2, 8'h01, 0, 1'b1, 1'b1);
        pulses = 0;
        repeat (4) begin send(1'b1); pulses += int'(match_o[2]); end
        check("len0_pulses", pulses, 0);
        cfg(2, 8'h01, 9, 1'b1, 1'b1);
        pulses = 0;
        repeat (4) begin send(1'b1); pulses += int'(match_o[2]); end
        check("len9_pulses", pulses, 0);
        cfg(2, 8'h01, 1, 1'b1, 1'b1);
        send(1'b1);
        check("len1_match", match_o, 3'b101);

        // Out-of-range select leaves everything untouched.
        do_rst();
        send(1'b1); send(1'b1); send(1'b1); send(1'b0);
        idle();
        check("oob_pre_cnt0", match_cnt_o[1:0], 1);
        cfg(3, 8'hFF, 1, 1'b1, 1'b1);
        check("oob_cnt0", match_cnt_o[1:0], 1);
        send(1'b1);
        check("oob_no_match", match_o, 3'b000);
        send(1'b1); send(1'b1); send(1'b0);
        check("oob_default_match", match_o, 3'b001);

        // Random traffic against the model.
        do_rst();
        for (int i = 0; i < 3000; i++) begin
            bit r, v, b, we, ovl, en, clr;
            int sel, len;
            logic [ML-1:0] pat;
            r   = ($urandom_range(0, 299) == 0);
            v   = ($urandom_range(0, 9) < 8);
            b   = 1'($urandom_range(0, 1));
            we  = ($urandom_range(0, 24) == 0);
            sel = $urandom_range(0, 3);
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4);
            pat = ML'($urandom);
            ovl = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 39) == 0);
            tick(r, v, b, we, sel, pat, len, ovl, en, clr);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
